// File: rtl/dfh_walker_pkg.sv
// dfh_walker_pkg: shared DFH layout, walker error codes and FSM states.
package dfh_walker_pkg;
  localparam int DFH_EOL_BIT = 40;
  localparam int DFH_ALIGN_W = 3;
  typedef struct packed {
    logic [3:0]  feat_type;
    logic [7:0]  rsvd_hi;
    logic [3:0]  afu_minor;
    logic [6:0]  rsvd_lo;
    logic        eol;
    logic [23:0] nxt_dfh_offset;
    logic [3:0]  afu_major;
    logic [11:0] feat_id;
  } t_dfh;
  typedef enum logic [2:0] {
    ERR_OK, ERR_LOOP, ERR_MAX, ERR_ADDR, ERR_ALIGN, ERR_TIMEOUT, ERR_ABORT
  } t_walk_err;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_EMIT, S_DONE, S_ERR} t_walk_state;
  function automatic logic off_misaligned(input logic [23:0] off);
    return |off[DFH_ALIGN_W-1:0];
  endfunction
endpackage

// File: rtl/dfh_walker_timeout.sv
// dfh_walker_timeout: response watchdog, cleared on entry to WAIT, expires after TIMEOUT_CYC cycles.
module dfh_walker_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  assign expired = run && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dfh_chain_walker.sv
// dfh_chain_walker: walks a DFH linked list over a CSR read port and streams one record per feature.
// Define DFH_WALKER_TIMEOUT_EN to enable the WAIT-state response watchdog (err 5).
module dfh_chain_walker import dfh_walker_pkg::*; #(
  parameter int ADDR_W      = 20,
  parameter int MAX_DFH     = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            start_addr,
  input  logic                         abort,
  output logic                         rd_req_valid,
  input  logic                         rd_req_ready,
  output logic [ADDR_W-1:0]            rd_req_addr,
  input  logic                         rd_rsp_valid,
  input  logic [63:0]                  rd_rsp_data,
  output logic                         feat_valid,
  input  logic                         feat_ready,
  output logic [$clog2(MAX_DFH)-1:0]   feat_idx,
  output logic [ADDR_W-1:0]            feat_addr,
  output logic [63:0]                  feat_dfh,
  output logic                         busy,
  output logic                         done,
  output logic [2:0]                   err_code,
  output logic [$clog2(MAX_DFH):0]     feat_count
);
  localparam int IW = $clog2(MAX_DFH);
  localparam int SW = (ADDR_W > 24 ? ADDR_W : 24) + 1;
  if (MAX_DFH < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("dfh_chain_walker: MAX_DFH must be >= 2 and TIMEOUT_CYC >= 1");
  end
  t_walk_state       state;
  t_walk_err         err;
  t_walk_err         chk_err;
  t_dfh              dfh_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     nxt_sum;
  logic              stale;
  logic              timeout;
  assign feat_dfh = dfh_q;
  assign err_code = err;
  assign nxt_sum  = SW'(cur_addr) + SW'(dfh_q.nxt_dfh_offset);
  // Sum is wide enough to hold any offset, so any bit above ADDR_W means the address left the CSR space.
  always_comb
    chk_err = dfh_q[DFH_EOL_BIT]                 ? ERR_OK    :
              dfh_q.nxt_dfh_offset == '0         ? ERR_LOOP  :
              off_misaligned(dfh_q.nxt_dfh_offset) ? ERR_ALIGN :
              |nxt_sum[SW-1:ADDR_W]              ? ERR_ADDR  :
              idx == IW'(MAX_DFH - 1)            ? ERR_MAX   : ERR_OK;
`ifdef DFH_WALKER_TIMEOUT_EN
  dfh_walker_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == S_REQ && rd_req_ready),
    .run     (state == S_WAIT),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= S_IDLE;
      err          <= ERR_OK;
      dfh_q        <= '0;
      cur_addr     <= '0;
      idx          <= '0;
      stale        <= 1'b0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      feat_valid   <= 1'b0;
      feat_idx     <= '0;
      feat_addr    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      feat_count   <= '0;
    end else begin
      done <= 1'b0;
      if (rd_rsp_valid) stale <= 1'b0;
      // A read already accepted by the slave will still answer; remember to drop it.
      if (abort && busy) begin
        state        <= S_ERR;
        err          <= ERR_ABORT;
        busy         <= 1'b0;
        done         <= 1'b1;
        rd_req_valid <= 1'b0;
        feat_valid   <= 1'b0;
        stale        <= (state == S_WAIT && !rd_rsp_valid) || (state == S_REQ && rd_req_ready);
      end else case (state)
        S_IDLE: if (start) begin
          cur_addr   <= start_addr;
          idx        <= '0;
          feat_count <= '0;
          if (|start_addr[DFH_ALIGN_W-1:0]) begin
            err   <= ERR_ALIGN;
            state <= S_ERR;
            done  <= 1'b1;
          end else begin
            err          <= ERR_OK;
            state        <= S_REQ;
            busy         <= 1'b1;
            rd_req_valid <= 1'b1;
            rd_req_addr  <= start_addr;
          end
        end
        S_REQ: if (rd_req_ready) begin
          rd_req_valid <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: if (rd_rsp_valid && !stale) begin
          dfh_q      <= t_dfh'(rd_rsp_data);
          feat_addr  <= cur_addr;
          feat_idx   <= idx;
          feat_valid <= 1'b1;
          state      <= S_EMIT;
        end else if (timeout) begin
          err   <= ERR_TIMEOUT;
          state <= S_ERR;
          busy  <= 1'b0;
          done  <= 1'b1;
          stale <= 1'b1;
        end
        S_EMIT: if (feat_ready) begin
          feat_valid <= 1'b0;
          feat_count <= feat_count + 1'b1;
          if (dfh_q[DFH_EOL_BIT] || chk_err != ERR_OK) begin
            err   <= chk_err;
            state <= dfh_q[DFH_EOL_BIT] ? S_DONE : S_ERR;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cur_addr     <= nxt_sum[ADDR_W-1:0];
            idx          <= idx + 1'b1;
            rd_req_valid <= 1'b1;
            rd_req_addr  <= nxt_sum[ADDR_W-1:0];
            state        <= S_REQ;
          end
        end
        S_DONE, S_ERR: state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_dfh_chain_walker.sv
// tb_dfh_chain_walker: randomized scoreboard bench against a list-walking reference model.
module tb_dfh_chain_walker;
  localparam int AW = 20, MAXD = 4, TO = 16, IW = $clog2(MAXD);
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic rd_req_ready = 0, rd_rsp_valid = 0, feat_ready = 0;
  logic [AW-1:0] start_addr = '0, rd_req_addr, feat_addr;
  logic [63:0] rd_rsp_data = '0, feat_dfh;
  logic rd_req_valid, feat_valid, busy, done;
  logic [IW-1:0] feat_idx;
  logic [2:0] err_code;
  logic [IW:0] feat_count;

  always #5 clk = ~clk;

  dfh_chain_walker #(.ADDR_W(AW), .MAX_DFH(MAXD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .abort(abort),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_idx(feat_idx),
    .feat_addr(feat_addr), .feat_dfh(feat_dfh), .busy(busy), .done(done),
    .err_code(err_code), .feat_count(feat_count));

  typedef struct {int idx; int addr; logic [63:0] dfh;} rec_t;
  typedef struct {int err; int cnt;} end_t;
  rec_t exp_rec[$];
  end_t exp_end[$];
  logic [63:0] mem [int];
  int checks = 0, passes = 0, fails = 0, reqs = 0;
  bit hold_rsp = 0, stall_en = 0, pend = 0;
  int stall_cnt = 0, paddr = 0, lat = 0;

  function automatic logic [63:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] mk(input bit eol, input int off);
    return {4'h3, 8'h0, 4'($urandom), 7'h0, eol, off[23:0], 4'h1, 12'($urandom)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: follow the list by address arithmetic, applying the stop rules in priority order.
  task automatic model(input int sa);
    int a, off, e;
    logic [63:0] d;
    a = sa;
    if (sa % 8 != 0) begin
      exp_end.push_back('{4, 0});
      return;
    end
    for (int i = 0; i < MAXD; i++) begin
      d = rd(a);
      off = int'(d[39:16]);
      exp_rec.push_back('{i, a, d});
      if (d[40]) e = 0;
      else if (off == 0) e = 1;
      else if (off % 8 != 0) e = 4;
      else if (a + off >= (1 << AW)) e = 3;
      else if (i == MAXD - 1) e = 2;
      else begin
        a += off;
        continue;
      end
      exp_end.push_back('{e, i + 1});
      return;
    end
  endtask

  // Read slave and consumer: random ready, random response latency.
  initial forever begin
    @(negedge clk);
    rd_rsp_valid = 0;
    if (pend && !hold_rsp) begin
      if (lat == 0) begin
        rd_rsp_valid = 1;
        rd_rsp_data = rd(paddr);
        pend = 0;
      end else lat--;
    end
    rd_req_ready = $urandom_range(0, 3) != 0;
    feat_ready = $urandom_range(0, 3) != 0;
    if (stall_en && feat_valid && feat_idx == 1 && stall_cnt < 20) begin
      feat_ready = 0;
      stall_cnt++;
    end
    if (rst_n && rd_req_valid && rd_req_ready) begin
      pend = 1;
      paddr = int'(rd_req_addr);
      lat = $urandom_range(0, 3);
      reqs++;
    end
  end

  // Monitor: pops the scoreboard on each record handshake and on each done pulse.
  initial begin
    bit prev_stall = 0;
    logic [IW-1:0] h_idx;
    logic [AW-1:0] h_addr;
    logic [63:0] h_dfh;
    rec_t r;
    end_t e;
    forever begin
      @(negedge clk);
      #1;
      if (prev_stall) begin
        check("hold_valid", 64'(feat_valid), 64'd1);
        check("hold_data", 64'({feat_idx, feat_addr, feat_dfh} == {h_idx, h_addr, h_dfh}), 64'd1);
        check("no_req_in_stall", 64'(rd_req_valid), 64'd0);
      end
      prev_stall = feat_valid && !feat_ready;
      h_idx = feat_idx;
      h_addr = feat_addr;
      h_dfh = feat_dfh;
      if (feat_valid && feat_ready) begin
        if (exp_rec.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rec: got idx %0d addr %0h, expected none", feat_idx, feat_addr);
        end else begin
          r = exp_rec.pop_front();
          check("rec_idx", 64'(feat_idx), 64'(r.idx));
          check("rec_addr", 64'(feat_addr), 64'(r.addr));
          check("rec_dfh", feat_dfh, r.dfh);
        end
      end
      if (done) begin
        if (exp_end.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got err %0d, expected no done", err_code);
        end else begin
          e = exp_end.pop_front();
          check("end_err", 64'(err_code), 64'(e.err));
          check("end_count", 64'(feat_count), 64'(e.cnt));
          check("recs_left", 64'(exp_rec.size()), 64'd0);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 0;
    pend = 0;
    exp_rec.delete();
    exp_end.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL %s_no_done: got no done after %0d cycles, expected done", name, n);
      do_reset();
    end else @(negedge clk);
  endtask

  task automatic walk(input int sa, input bit stray);
    int n = 0;
    model(sa);
    stall_cnt = 0;
    @(negedge clk);
    start = 1;
    start_addr = AW'(sa);
    @(negedge clk);
    start = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      start = stray && n == 2;
      start_addr = AW'(sa + 8);
    end
    start = 0;
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL walk_no_done: start %0h got no done, expected done", sa);
      do_reset();
    end else @(negedge clk);
  endtask

  task automatic chain3();
    mem.delete();
    mem[0] = mk(0, 'h1000);
    mem['h1000] = mk(0, 'h2000);
    mem['h3000] = mk(1, 0);
  endtask

  initial begin
    int r0, base, len, a, off, rr;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 64'(rd_req_valid), 64'd0);
    check("rst_feat_valid", 64'(feat_valid), 64'd0);
    check("rst_busy_done", 64'({busy, done}), 64'd0);
    check("rst_err_count", 64'({err_code, feat_count}), 64'd0);
    @(negedge clk);
    rst_n = 1;

    chain3();
    walk(0, 1);
    check("chain3_count", 64'(feat_count), 64'd3);
    check("chain3_err", 64'(err_code), 64'd0);

    mem.delete();
    mem[0] = mk(0, 0);
    walk(0, 0);
    check("loop_err", 64'(err_code), 64'd1);
    check("loop_count", 64'(feat_count), 64'd1);

    mem.delete();
    for (int k = 0; k < 10; k++) mem['h100 * (k + 1)] = mk(k == 9, 'h100);
    walk('h100, 0);
    check("max_err", 64'(err_code), 64'd2);
    check("max_count", 64'(feat_count), 64'd4);

    chain3();
    stall_en = 1;
    walk(0, 0);
    stall_en = 0;
    check("stall_cycles", 64'(stall_cnt), 64'd20);
    check("stall_count", 64'(feat_count), 64'd3);

    mem.delete();
    mem[0] = mk(0, 'h1004);
    walk(0, 0);
    check("misoff_err", 64'(err_code), 64'd4);
    check("misoff_count", 64'(feat_count), 64'd1);

    r0 = reqs;
    walk('h6, 0);
    check("misstart_err", 64'(err_code), 64'd4);
    check("misstart_count", 64'(feat_count), 64'd0);
    check("misstart_no_read", 64'(reqs), 64'(r0));

    mem.delete();
    mem['hFF000] = mk(0, 'h2000);
    walk('hFF000, 0);
    check("addr_ovf_err", 64'(err_code), 64'd3);

    // Abort while the read is outstanding; its late response must be dropped.
    mem.delete();
    mem[0] = mk(1, 0);
    exp_end.push_back('{6, 0});
    hold_rsp = 1;
    @(negedge clk);
    start = 1;
    start_addr = '0;
    @(negedge clk);
    start = 0;
    for (int n = 0; n < 200 && !pend; n++) @(negedge clk);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done("abort");
    hold_rsp = 0;
    repeat (8) @(negedge clk);
    check("abort_err", 64'(err_code), 64'd6);
    check("abort_idle", 64'({busy, feat_valid, rd_req_valid}), 64'd0);
    chain3();
    walk(0, 0);
    check("after_abort_count", 64'(feat_count), 64'd3);

`ifdef DFH_WALKER_TIMEOUT_EN
    mem.delete();
    mem[0] = mk(1, 0);
    exp_end.push_back('{5, 0});
    hold_rsp = 1;
    @(negedge clk);
    start = 1;
    start_addr = '0;
    @(negedge clk);
    start = 0;
    wait_done("timeout");
    hold_rsp = 0;
    repeat (8) @(negedge clk);
    check("timeout_err", 64'(err_code), 64'd5);
`endif

    for (int t = 0; t < 40; t++) begin
      mem.delete();
      base = ($urandom_range(0, 4) == 0) ? 'hFF000 + $urandom_range(0, 'h1FF) * 8 : $urandom_range(0, 'h1000) * 8;
      len = $urandom_range(1, 6);
      a = base;
      for (int i = 0; i < len; i++) begin
        rr = $urandom_range(0, 15);
        off = rr == 0 ? 0 : rr == 1 ? $urandom_range(1, 'h200) * 8 + 4 : $urandom_range(1, 'h200) * 8;
        mem[a] = mk(i == len - 1 || $urandom_range(0, 7) == 0, off);
        a += off;
      end
      walk(base + ($urandom_range(0, 9) == 0 ? 4 : 0), $urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
